serial_deserializer: RTL

//  Serial-in/parallel-out receiver: the far end of the shift-register serializer link.

---
 rtl/serial_deserializer_if.sv | 29 ++
 rtl/serial_deserializer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_deserializer_if.sv
// Bundle for the serial_deserializer: serial input beat, parallel word handshake and status.
// slave = the deserializer itself, master = the serial source / word consumer.
interface serial_deserializer_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N) + 1;

  logic          sin;
  logic          sin_valid;
  logic          sof;
  logic          dir;
  logic [N-1:0]  Q;
  logic          q_valid;
  logic          q_ready;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          frame_err;

  modport slave (
    input  sin, sin_valid, sof, dir, q_ready,
    output Q, q_valid, busy, bit_cnt, overrun, frame_err
  );

  modport master (
    output sin, sin_valid, sof, dir, q_ready,
    input  Q, q_valid, busy, bit_cnt, overrun, frame_err
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver: assembles an N-bit frame (LSB- or MSB-first) into a
// single holding register presented on a valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for a beat with sof; non-sof beats are ignored
//   SHIFT | frame in progress, bit_cnt bits already collected
module serial_deserializer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  serial_deserializer_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sh, sh_nxt;
  logic [N-1:0]  q, q_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_q, dir_nxt;
  logic          q_valid, q_valid_nxt;
  logic          overrun, overrun_nxt;
  logic          ferr, ferr_nxt;

  logic          start;
  logic          shift_bit;
  logic          complete;
  logic          use_dir;
  logic [N-1:0]  sh_base;
  logic [N-1:0]  sh_shifted;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    cnt_nxt     = cnt;
    dir_nxt     = dir_q;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    overrun_nxt = overrun;
    ferr_nxt    = 1'b0;
    shift_bit   = 1'b0;
    complete    = 1'b0;

    // A sof beat (first frame or restart) starts from a clean register with the new dir.
    start      = bus.sin_valid && bus.sof;
    sh_base    = start ? '0 : sh;
    use_dir    = start ? bus.dir : dir_q;
    sh_shifted = use_dir ? {sh_base[N-2:0], bus.sin} : {bus.sin, sh_base[N-1:1]};

    case (state)
      IDLE: begin
        if (start) begin
          dir_nxt   = bus.dir;
          cnt_nxt   = CW'(1);
          shift_bit = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          shift_bit = 1'b1;
          if (bus.sof) begin
            ferr_nxt = 1'b1;
            dir_nxt  = bus.dir;
            cnt_nxt  = CW'(1);
          end else if (cnt == LAST) begin
            complete  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (shift_bit) sh_nxt = sh_shifted;

    if (q_valid && bus.q_ready) q_valid_nxt = 1'b0;

    // The holding register only accepts a new word if it is empty or being drained now.
    if (complete) begin
      if (!q_valid || bus.q_ready) begin
        q_nxt       = sh_shifted;
        q_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sh      <= '0;
      q       <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      sh      <= sh_nxt;
      q       <= q_nxt;
      cnt     <= cnt_nxt;
      dir_q   <= dir_nxt;
      q_valid <= q_valid_nxt;
      overrun <= overrun_nxt;
      ferr    <= ferr_nxt;
    end
  end

  assign bus.Q         = q;
  assign bus.q_valid   = q_valid;
  assign bus.busy      = (state == SHIFT);
  assign bus.bit_cnt   = cnt;
  assign bus.overrun   = overrun;
  assign bus.frame_err = ferr;
endmodule
